// File: rtl/qnn_pkg.sv
// ============================================================================
// qnn_pkg : shared types and helpers for the quantized feature-map datapath
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package qnn_pkg;

  localparam int PIX_W = 8;

  typedef logic [7:0] dim_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Address width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qfmap_ram.sv
// ============================================================================
// qfmap_ram : simple dual-port frame buffer, sync write, 1-cycle sync read
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module qfmap_ram #(
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read data register holds while rd_en is low; this is the stall hold path.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/quantized_fmap_streamer.sv
// ============================================================================
// quantized_fmap_streamer : buffers one INT8 feature map, streams it row-major
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module quantized_fmap_streamer
  import qnn_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_en,
  input  logic [clog2_min1(WIDTH*HEIGHT)-1:0] wr_addr,
  input  logic [CHANNELS*PIX_W-1:0]    wr_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CHANNELS*PIX_W-1:0]    m_data,
  output logic                         m_sof,
  output logic                         m_eol,
  output logic                         m_eof,
  output logic [7:0]                   m_row,
  output logic [7:0]                   m_col
);

  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int ADDR_W = clog2_min1(DEPTH);
  localparam int DATA_W = CHANNELS * PIX_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam dim_t LAST_COL = dim_t'(WIDTH - 1);
  localparam dim_t LAST_ROW = dim_t'(HEIGHT - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  dim_t              row;
  dim_t              col;
  logic [DATA_W-1:0] ram_q;
  logic              xfer;
  logic              last;
  logic              wr_ok;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  assign xfer  = m_valid && m_ready;
  assign last  = (row == LAST_ROW) && (col == LAST_COL);
  assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < DEPTH_C);

  // FETCH primes pixel 0; each non-final transfer prefetches the next pixel.
  assign rd_en   = (state == FETCH) || (xfer && !last);
  assign rd_addr = (state == FETCH) ? '0 : ptr + 1'b1;

  qfmap_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      m_valid <= 1'b0;
      ptr     <= '0;
      row     <= '0;
      col     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
            ptr   <= '0;
            row   <= '0;
            col   <= '0;
          end
        end
        FETCH: begin
          state   <= STREAM;
          m_valid <= 1'b1;
        end
        STREAM: begin
          if (xfer) begin
            if (last) begin
              state   <= DONE;
              m_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              row     <= '0;
              col     <= '0;
            end else begin
              ptr <= ptr + 1'b1;
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer has no reset, so data is masked to zero whenever no beat is offered.
  assign m_data = m_valid ? ram_q : '0;
  assign m_sof  = m_valid && (row == '0) && (col == '0);
  assign m_eol  = m_valid && (col == LAST_COL);
  assign m_eof  = m_valid && last;
  assign m_row  = row;
  assign m_col  = col;

endmodule

`default_nettype wire

// File: tb/tb_quantized_fmap_streamer.sv
// ============================================================================
// tb_quantized_fmap_streamer : randomized bench with a behavioural frame model
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_quantized_fmap_streamer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int D = W * H;

  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_STRM = 2, PH_FIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        m_ready = 1'b0;
  logic        busy, done, m_valid, m_sof, m_eol, m_eof;
  logic [15:0] m_data;
  logic [7:0]  m_row, m_col;

  quantized_fmap_streamer #(.CHANNELS(2), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .m_row(m_row), .m_col(m_col)
  );

  logic       wr_en1 = 1'b0;
  logic [0:0] wr_addr1 = '0;
  logic [7:0] wr_data1 = '0;
  logic       start1 = 1'b0;
  logic       busy1, done1, valid1, sof1, eol1, eof1;
  logic [7:0] data1, row1, col1;

  quantized_fmap_streamer #(.CHANNELS(1), .WIDTH(1), .HEIGHT(1)) dut1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .start(start1), .busy(busy1), .done(done1), .m_valid(valid1), .m_ready(1'b1),
    .m_data(data1), .m_sof(sof1), .m_eol(eol1), .m_eof(eof1),
    .m_row(row1), .m_col(col1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        eof;
    logic        eol;
    logic        sof;
    logic [15:0] d;
  } beat_t;

  logic [15:0] mem [D];
  int          ph = PH_IDLE;
  int          idx = 0;
  bit          just_reset = 1'b0;
  beat_t       cap[$];
  int          done_cnt = 0;

  // Frame model: after each edge, compare DUT outputs, then advance on the sampled inputs.
  always @(negedge clk) begin
    if (just_reset) begin
      chk("reset_ctl", {busy, done, m_valid, m_sof, m_eol, m_eof}, 0);
      chk("reset_dat", {m_data, m_row, m_col}, 0);
    end else begin
      chk("ctl", {busy, done, m_valid}, {ph == PH_WAIT || ph == PH_STRM, ph == PH_FIN, ph == PH_STRM});
      if (ph == PH_STRM) begin
        chk("data", m_data, mem[idx]);
        chk("idx", {m_row, m_col}, {8'(idx / W), 8'(idx % W)});
        chk("flags", {m_sof, m_eol, m_eof}, {idx == 0, (idx % W) == W - 1, idx == D - 1});
      end
    end
    if (m_valid && m_ready) cap.push_back('{eof: m_eof, eol: m_eol, sof: m_sof, d: m_data});
    if (done) done_cnt++;

    just_reset = 1'b0;
    if (!rstn) begin
      ph = PH_IDLE;
      idx = 0;
      just_reset = 1'b1;
    end else begin
      case (ph)
        PH_IDLE: begin
          if (wr_en && int'(wr_addr) < D) mem[wr_addr] = wr_data;
          if (start) ph = PH_WAIT;
        end
        PH_WAIT: begin
          ph = PH_STRM;
          idx = 0;
        end
        PH_STRM: begin
          if (m_ready) begin
            if (idx == D - 1) ph = PH_FIN;
            else idx++;
          end
        end
        default: ph = PH_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // mode 0: ready high, 1: 1,0,0,1 pattern, 2: random ready.
  task automatic run_frame(input int mode, input bit poke);
    bit ok;
    bit poked;
    cap.delete();
    done_cnt = 0;
    ok = 1'b0;
    poked = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && !poked && cap.size() == 5) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = 4'd0;
        wr_data = 16'h00FF;
        poked = 1'b1;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      if (done) ok = 1'b1;
    end
    chk("frame_done_seen", ok, 1);
    start = poke;
    tick();
    start = 1'b0;
    chk("idle_after_done", {busy, done, m_valid}, 3'b000);
    chk("done_pulses", done_cnt, 1);
    chk("beat_count", cap.size(), D);
  endtask

  logic [15:0] snap [D];
  logic [11:0] sofv, eolv, eofv;
  bit          hit;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_ready = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Ramp data on ch0, random ch1.
    for (int a = 0; a < D; a++) write_px(a, {8'($urandom_range(0, 255)), 8'(a * 3)});
    run_frame(0, 1'b0);
    sofv = '0; eolv = '0; eofv = '0;
    for (int i = 0; i < cap.size() && i < 12; i++) begin
      sofv[i] = cap[i].sof;
      eolv[i] = cap[i].eol;
      eofv[i] = cap[i].eof;
    end
    chk("t1_beat0", cap[0].d[7:0], 8'd0);
    chk("t1_beat5", cap[5].d[7:0], 8'd15);
    chk("t1_beat11", cap[11].d[7:0], 8'd33);
    chk("t1_sof_vec", sofv, 12'h001);
    chk("t1_eol_vec", eolv, 12'h888);
    chk("t1_eof_vec", eofv, 12'h800);

    run_frame(1, 1'b0);
    for (int i = 0; i < cap.size() && i < D; i++) chk("t2_order", cap[i].d, mem[i]);

    for (int a = 0; a < D; a++) write_px(a, {8'(8'hA0 + a), 8'(a)});
    run_frame(2, 1'b0);
    chk("t3_beat7", cap[7].d, 16'hA707);
    chk("t3_beat11", cap[11].d, 16'hAB0B);

    run_frame(0, 1'b1);
    run_frame(2, 1'b0);
    chk("t4_write_dropped", cap[0].d, 16'hA000);

    cap.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_ready = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      if (cap.size() >= 5) hit = 1'b1;
      else tick();
    end
    chk("t5_reached_beat5", hit, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("t5_abort", {busy, m_valid, done}, 3'b000);
    repeat (4) tick();
    chk("t5_no_done", done_cnt, 0);
    run_frame(0, 1'b0);
    chk("t5_restart_beat0", {cap[0].sof, cap[0].d}, {1'b1, 16'hA000});

    for (int a = 0; a < D; a++) snap[a] = mem[a];
    write_px(12, 16'h0055);
    write_px(15, 16'h0055);
    run_frame(0, 1'b0);
    for (int i = 0; i < cap.size() && i < D; i++) chk("t6_unchanged", cap[i].d, snap[i]);

    for (int f = 0; f < 3; f++) begin
      for (int a = 0; a < D; a++) write_px(a, 16'($urandom()));
      run_frame(2, 1'b0);
    end

    wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_data1 = 8'h5A;
    tick();
    wr_addr1 = 1'b1; wr_data1 = 8'h55;
    tick();
    wr_en1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("one_fetch", {busy1, valid1}, 2'b10);
    tick();
    chk("one_beat", {valid1, sof1, eol1, eof1, data1, row1, col1}, {4'hF, 8'h5A, 16'h0000});
    tick();
    chk("one_done", {done1, busy1, valid1}, 3'b100);
    tick();
    chk("one_idle", {done1, busy1, valid1}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
